// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine program controller.
//   state_t    : phase encoding, also driven directly onto the stage port
//   MODE_*     : program-select codes latched at start
//   quick_dur  : duration used by the quick program, max(d>>1, 1)
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] MODE_NORMAL     = 2'b00;
  localparam logic [1:0] MODE_QUICK      = 2'b01;
  localparam logic [1:0] MODE_RINSE_SPIN = 2'b10;
  localparam logic [1:0] MODE_SPIN_ONLY  = 2'b11;

  function automatic int unsigned quick_dur(input int unsigned d);
    return ((d >> 1) == 0) ? 1 : (d >> 1);
  endfunction

endpackage

// File: rtl/wash_phase_timer.sv
// Phase timer: counts cycles spent in the current phase.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : advance the count this cycle
//   dur      : current phase length in cycles
//   expire   : en & (count == dur-1), i.e. the phase ends on this edge
module wash_phase_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [TIMER_W-1:0] dur,
  output logic               expire
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  assign expire = en & (count == dur - 1'b1);

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine program controller: sequences FILL, WASH, RINSE x n, SPIN
// and DONE according to the program latched at start.
//   clk, rst           : clock, async active-high reset
//   start, mode, rinses: program request and selection (sampled in IDLE)
//   supply, door_closed: run enable; either low pauses the program
//   abort              : force the running program to DONE
//   stage              : current phase (0 IDLE .. 5 DONE)
//   busy, door_lock    : program in progress
//   paused             : busy but held by supply/door
//   done               : one-cycle pulse in DONE
//   rinse_idx          : zero-based rinse pass, 0 outside RINSE
//
// state    | meaning
// IDLE     | waiting for an accepted start
// FILL     | water inlet
// WASH     | main wash (normal/quick only)
// RINSE    | rinse passes back-to-back, rinse_idx counts them
// SPIN     | final spin
// DONE     | one cycle, then back to IDLE
module wash_cycle_ctrl
  import wash_pkg::*;
#(
  parameter int TIMER_W    = 16,
  parameter int FILL_TIME  = 3,
  parameter int WASH_TIME  = 4,
  parameter int RINSE_TIME = 4,
  parameter int SPIN_TIME  = 4,
  parameter int MAX_RINSES = 3,
  parameter int RC_W       = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [RC_W-1:0] rinses,
  input  logic            supply,
  input  logic            door_closed,
  input  logic            abort,
  output logic [2:0]      stage,
  output logic            busy,
  output logic            door_lock,
  output logic            paused,
  output logic            done,
  output logic [RC_W-1:0] rinse_idx
);

  localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_RINSES);

  state_t             state, state_nx;
  logic [1:0]         mode_q;
  logic [RC_W-1:0]    n_q, idx_q, idx_nx;
  logic               paused_q;
  logic               run_en, in_phase, start_ok, phase_end;
  logic [TIMER_W-1:0] dur;
  int unsigned        base_dur;

  assign run_en   = supply & door_closed;
  assign in_phase = (state == ST_FILL) || (state == ST_WASH) ||
                    (state == ST_RINSE) || (state == ST_SPIN);
  assign start_ok = (state == ST_IDLE) & start & run_en;

  always_comb begin
    base_dur = 1;
    case (state)
      ST_FILL:  base_dur = FILL_TIME;
      ST_WASH:  base_dur = WASH_TIME;
      ST_RINSE: base_dur = RINSE_TIME;
      ST_SPIN:  base_dur = SPIN_TIME;
      default:  base_dur = 1;
    endcase
    dur = TIMER_W'((mode_q == MODE_QUICK) ? quick_dur(base_dur) : base_dur);
  end

  // Cleared on every phase end (including rinse pass to rinse pass) and
  // held at zero outside the timed phases, so each phase starts from 0.
  wash_phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (phase_end | ~in_phase),
    .en     (run_en & in_phase),
    .dur    (dur),
    .expire (phase_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_NORMAL;
      n_q    <= '0;
    end else if (start_ok) begin
      mode_q <= mode;
      if (rinses == '0)         n_q <= RC_W'(1);
      else if (rinses > RC_MAX) n_q <= RC_MAX;
      else                      n_q <= rinses;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx_q;
    case (state)
      ST_IDLE:
        if (start_ok) state_nx = (mode == MODE_SPIN_ONLY) ? ST_SPIN : ST_FILL;
      ST_FILL:
        if (abort) state_nx = ST_DONE;
        else if (phase_end)
          state_nx = (mode_q == MODE_RINSE_SPIN) ? ST_RINSE : ST_WASH;
      ST_WASH:
        if (abort) state_nx = ST_DONE;
        else if (phase_end) state_nx = ST_RINSE;
      ST_RINSE:
        if (abort) state_nx = ST_DONE;
        else if (phase_end) begin
          if (idx_q == n_q - 1'b1) state_nx = ST_SPIN;
          else                     idx_nx   = idx_q + 1'b1;
        end
      ST_SPIN:
        if (abort) state_nx = ST_DONE;
        else if (phase_end) state_nx = ST_DONE;
      ST_DONE:
        state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
    if (state_nx != ST_RINSE) idx_nx = '0;
  end

  // paused is registered from the run_en sampled at the edge, so it is high
  // exactly in the cycles that follow an edge where a busy state was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx_q    <= '0;
      paused_q <= 1'b0;
    end else begin
      state    <= state_nx;
      idx_q    <= idx_nx;
      paused_q <= (state_nx != ST_IDLE) & ~run_en;
    end
  end

  assign stage     = state;
  assign busy      = (state != ST_IDLE);
  assign door_lock = busy;
  assign paused    = paused_q;
  assign done      = (state == ST_DONE);
  assign rinse_idx = idx_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
module tb_wash_cycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] rinses = 2'b00;
  logic       supply = 1'b1;
  logic       door_closed = 1'b1;
  logic       abort = 1'b0;
  logic [2:0] stage;
  logic       busy, door_lock, paused, done;
  logic [1:0] rinse_idx;

  wash_cycle_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .rinses      (rinses),
    .supply      (supply),
    .door_closed (door_closed),
    .abort       (abort),
    .stage       (stage),
    .busy        (busy),
    .door_lock   (door_lock),
    .paused      (paused),
    .done        (done),
    .rinse_idx   (rinse_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] stage;
    logic       busy;
    logic       paused;
    logic       done;
    logic [1:0] ridx;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  // Monitor: one expectation per cycle, compared mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      n_vec++;
      if ({stage, busy, door_lock, paused, done, rinse_idx} !==
          {mon_e.stage, mon_e.busy, mon_e.busy, mon_e.paused, mon_e.done, mon_e.ridx}) begin
        n_bad++;
        $display("FAIL %s @%0t: got stage=%0d busy=%0d lock=%0d paused=%0d done=%0d idx=%0d, want stage=%0d busy=%0d lock=%0d paused=%0d done=%0d idx=%0d",
                 mon_e.name, $time, stage, busy, door_lock, paused, done, rinse_idx,
                 mon_e.stage, mon_e.busy, mon_e.busy, mon_e.paused, mon_e.done, mon_e.ridx);
      end
    end
  end

  // Push the expectation for the sample after the next rising edge, then
  // step to just past the following falling edge.
  task automatic cyc(input logic [2:0] st, input logic [1:0] ri, input logic pz, input string nm);
    exp_t e;
    e.stage  = st;
    e.busy   = (st != 3'd0);
    e.paused = pz;
    e.done   = (st == 3'd5);
    e.ridx   = ri;
    e.name   = nm;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic ph(input logic [2:0] st, input int n, input logic [1:0] ri, input string nm);
    for (int i = 0; i < n; i++) cyc(st, ri, 1'b0, nm);
  endtask

  task automatic launch(input logic [1:0] m, input logic [1:0] r, input logic [2:0] first, input string nm);
    mode   = m;
    rinses = r;
    start  = 1'b1;
    cyc(first, 2'd0, 1'b0, nm);
    start  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    #1;
    cyc(3'd0, 2'd0, 1'b0, "reset_state");
    rst = 1'b0;
    cyc(3'd0, 2'd0, 1'b0, "idle");

    // normal, 2 rinses: DONE 19 cycles after start
    launch(2'b00, 2'd2, 3'd1, "n_fill");
    ph(3'd1, 2, 2'd0, "n_fill");
    ph(3'd2, 4, 2'd0, "n_wash");
    ph(3'd3, 4, 2'd0, "n_rinse0");
    ph(3'd3, 4, 2'd1, "n_rinse1");
    ph(3'd4, 4, 2'd0, "n_spin");
    cyc(3'd5, 2'd0, 1'b0, "n_done");
    cyc(3'd0, 2'd0, 1'b0, "n_idle");

    // quick, 1 rinse; start held during WASH must be ignored
    launch(2'b01, 2'd1, 3'd1, "q_fill");
    start = 1'b1;
    ph(3'd2, 2, 2'd0, "q_wash_start_ignored");
    start = 1'b0;
    ph(3'd3, 2, 2'd0, "q_rinse");
    ph(3'd4, 2, 2'd0, "q_spin");
    cyc(3'd5, 2'd0, 1'b0, "q_done");
    cyc(3'd0, 2'd0, 1'b0, "q_idle");

    // supply loss for 5 cycles mid-WASH
    launch(2'b00, 2'd1, 3'd1, "s_fill");
    ph(3'd1, 2, 2'd0, "s_fill");
    ph(3'd2, 2, 2'd0, "s_wash");
    supply = 1'b0;
    for (int i = 0; i < 5; i++) cyc(3'd2, 2'd0, 1'b1, "s_paused");
    supply = 1'b1;
    ph(3'd2, 2, 2'd0, "s_wash_resume");
    ph(3'd3, 4, 2'd0, "s_rinse");
    ph(3'd4, 4, 2'd0, "s_spin");
    cyc(3'd5, 2'd0, 1'b0, "s_done");
    cyc(3'd0, 2'd0, 1'b0, "s_idle");

    // abort during rinse pass 0, then abort in IDLE is ignored
    launch(2'b00, 2'd2, 3'd1, "a_fill");
    ph(3'd1, 2, 2'd0, "a_fill");
    ph(3'd2, 4, 2'd0, "a_wash");
    ph(3'd3, 2, 2'd0, "a_rinse0");
    abort = 1'b1;
    cyc(3'd5, 2'd0, 1'b0, "a_done");
    cyc(3'd0, 2'd0, 1'b0, "a_idle_abort_ignored");
    abort = 1'b0;
    cyc(3'd0, 2'd0, 1'b0, "a_idle");

    // start rejected with the door open
    door_closed = 1'b0;
    mode = 2'b00;
    start = 1'b1;
    cyc(3'd0, 2'd0, 1'b0, "r_door_open");
    cyc(3'd0, 2'd0, 1'b0, "r_door_open");
    start = 1'b0;
    door_closed = 1'b1;
    cyc(3'd0, 2'd0, 1'b0, "r_idle");

    // rinse+spin, rinses=0 clamps to one pass
    launch(2'b10, 2'd0, 3'd1, "rs0_fill");
    ph(3'd1, 2, 2'd0, "rs0_fill");
    ph(3'd3, 4, 2'd0, "rs0_rinse0");
    ph(3'd4, 4, 2'd0, "rs0_spin");
    cyc(3'd5, 2'd0, 1'b0, "rs0_done");
    cyc(3'd0, 2'd0, 1'b0, "rs0_idle");

    // rinse+spin, 3 passes
    launch(2'b10, 2'd3, 3'd1, "rs3_fill");
    ph(3'd1, 2, 2'd0, "rs3_fill");
    ph(3'd3, 4, 2'd0, "rs3_rinse0");
    ph(3'd3, 4, 2'd1, "rs3_rinse1");
    ph(3'd3, 4, 2'd2, "rs3_rinse2");
    ph(3'd4, 4, 2'd0, "rs3_spin");
    cyc(3'd5, 2'd0, 1'b0, "rs3_done");
    cyc(3'd0, 2'd0, 1'b0, "rs3_idle");

    // spin-only
    launch(2'b11, 2'd0, 3'd4, "so_spin");
    ph(3'd4, 3, 2'd0, "so_spin");
    cyc(3'd5, 2'd0, 1'b0, "so_done");
    cyc(3'd0, 2'd0, 1'b0, "so_idle");

    // asynchronous reset mid-SPIN
    launch(2'b11, 2'd0, 3'd4, "rst_spin");
    ph(3'd4, 1, 2'd0, "rst_spin");
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({stage, busy, door_lock, paused, done, rinse_idx} !== 9'd0) begin
      n_bad++;
      $display("FAIL async_reset @%0t: got stage=%0d busy=%0d lock=%0d paused=%0d done=%0d idx=%0d, want all 0",
               $time, stage, busy, door_lock, paused, done, rinse_idx);
    end
    cyc(3'd0, 2'd0, 1'b0, "rst_hold");
    rst = 1'b0;
    cyc(3'd0, 2'd0, 1'b0, "rst_release");

    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
